// File: rtl/fir_tap_accumulator.sv
// Sums TAPS signed products per output sample, then rounds half-up, shifts and narrows to 16 bits.
// Optional macro SATURATE_EN: clamp the narrowed sample and raise a sticky sat flag.
module fir_tap_accumulator #(
  parameter int unsigned TAPS  = 32,
  parameter int unsigned SHIFT = 16,
  parameter int unsigned ACC_W = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] prod_in,
  input  logic        sync,
  output logic        out_valid,
  output logic [15:0] data_out,
  output logic [7:0]  tap_idx,
  output logic        sat
);

  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state, state_nx;
  logic signed [ACC_W-1:0]  acc, acc_nx;
  logic [IDX_W-1:0]         tap_nx;
  logic                     emit_nx;
  logic [31:0]              prod_m_c;
  logic signed [ACC_W-1:0]  prod_ext_c, sum_c, rnd_c;
  logic [15:0]              sample_c;
  logic                     clamp_c;

  // Upstream marker bit is masked off before the product is accumulated
  assign prod_m_c   = prod_in & 32'hFFFF_FFFE;
  assign prod_ext_c = {{(ACC_W-32){prod_m_c[31]}}, prod_m_c};
  assign sum_c      = acc + prod_ext_c;
  assign rnd_c      = (sum_c + HALF) >>> SHIFT;

`ifdef SATURATE_EN
  logic pos_ovf_c, neg_ovf_c;
  assign pos_ovf_c = !rnd_c[ACC_W-1] && (|rnd_c[ACC_W-2:15]);
  assign neg_ovf_c = rnd_c[ACC_W-1] && !(&rnd_c[ACC_W-2:15]);
  assign clamp_c   = pos_ovf_c | neg_ovf_c;
  assign sample_c  = pos_ovf_c ? 16'h7FFF : (neg_ovf_c ? 16'h8000 : 16'(rnd_c));
`else
  assign clamp_c   = 1'b0;
  assign sample_c  = 16'(rnd_c);
`endif

  // Next-state: sync overrides everything, including a completing final tap
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    tap_nx   = tap_idx;
    emit_nx  = 1'b0;
    if (sync) begin
      state_nx = IDLE;
      acc_nx   = '0;
      tap_nx   = '0;
      if (in_valid) begin
        state_nx = ACCUM;
        acc_nx   = prod_ext_c;
        tap_nx   = IDX_W'(1);
      end
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          state_nx = ACCUM;
          acc_nx   = prod_ext_c;
          tap_nx   = IDX_W'(1);
        end
        ACCUM: begin
          if (tap_idx == LAST_TAP) begin
            state_nx = IDLE;
            acc_nx   = '0;
            tap_nx   = '0;
            emit_nx  = 1'b1;
          end else begin
            acc_nx = sum_c;
            tap_nx = tap_idx + IDX_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          acc_nx   = '0;
          tap_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      tap_idx   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      tap_idx   <= tap_nx;
      out_valid <= emit_nx;
      if (emit_nx) data_out <= sample_c;
    end
  end

`ifdef SATURATE_EN
  // Sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     sat <= 1'b0;
    else if (emit_nx && clamp_c) sat <= 1'b1;
  end
`else
  assign sat = clamp_c;
`endif

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Scoreboard bench for fir_tap_accumulator (TAPS=4, SHIFT=4) with a queue-based frame model.
module tb_fir_tap_accumulator;

  localparam int unsigned TAPS  = 4;
  localparam int unsigned SHIFT = 4;
  localparam int unsigned ACC_W = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] prod_in;
  logic        sync;
  logic        out_valid;
  logic [15:0] data_out;
  logic [7:0]  tap_idx;
  logic        sat;

  fir_tap_accumulator #(.TAPS(TAPS), .SHIFT(SHIFT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .prod_in(prod_in), .sync(sync),
    .out_valid(out_valid), .data_out(data_out), .tap_idx(tap_idx), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frame[$];
  int          pulse_cyc[$];
  int          exp_tap = 0;
  bit          sat_exp = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum of a complete frame, round half up, arithmetic shift, narrow
  task automatic model_emit();
    longint s = 0;
    longint r;
    exp_t   e;
    bit     clamp = 1'b0;
    foreach (frame[i]) s += longint'($signed(frame[i] & 32'hFFFF_FFFE));
    r = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef SATURATE_EN
    if (r > 32767) begin e.data = 16'h7FFF; clamp = 1'b1; end
    else if (r < -32768) begin e.data = 16'h8000; clamp = 1'b1; end
    else e.data = 16'(r);
`else
    e.data = 16'(r);
`endif
    sat_exp = sat_exp | clamp;
    e.sat   = sat_exp;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit v, input logic [31:0] p, input bit s);
    if (s) frame.delete();
    if (v) begin
      frame.push_back(p);
      if (frame.size() == TAPS) begin
        model_emit();
        frame.delete();
      end
    end
    exp_tap = frame.size();
  endtask

  // Entered and left at posedge+2
  task automatic drive(input bit v, input logic [31:0] p, input bit s);
    in_valid = v;
    prod_in  = p;
    sync     = s;
    model_step(v, p, s);
    @(posedge clk); #1;
    chk("tap_idx", longint'(tap_idx), longint'(exp_tap));
    #1;
    in_valid = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk); #2;
    end
    chk("drain_pending", longint'(exp_q.size()), 0);
  endtask

  task automatic frame4(input logic [31:0] p, input int gap);
    for (int i = 0; i < TAPS; i++) begin
      drive(1'b1, p, 1'b0);
      if (gap > 0 && i < TAPS - 1) idle(gap);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_data_out"},  longint'(data_out), 0);
    chk({tag, "_tap_idx"},   longint'(tap_idx), 0);
    chk({tag, "_sat"},       longint'(sat), 0);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every pulse must match the oldest expected sample
  always begin
    exp_t e;
    @(posedge clk); #1;
    if (out_valid) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: data_out 0x%0h with no sample expected at %0t", data_out, $time);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", longint'(data_out), longint'(e.data));
        chk("sat", longint'(sat), longint'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; prod_in = '0; sync = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // 1: small contiguous frame
    frame4(32'h11, 0);
    drain();
    chk("t1_value", longint'(data_out), 16'h0004);

    // 2: negative products, rounding on halves
    frame4(32'hFFFF_FFF1, 0);
    drain();
    chk("t2_value", longint'(data_out), 16'hFFFC);

    // 3: idle gaps mid-frame
    frame4(32'h11, 3);
    drain();
    chk("t3_value", longint'(data_out), 16'h0004);

    // 4: back-to-back frames, pulses four cycles apart
    pulse_cyc.delete();
    frame4(32'h11, 0);
    frame4(32'h21, 0);
    drain();
    chk("t4_pulses", longint'(pulse_cyc.size()), 2);
    if (pulse_cyc.size() == 2) chk("t4_spacing", longint'(pulse_cyc[1] - pulse_cyc[0]), TAPS);
    chk("t4_value", longint'(data_out), 16'h0008);

    // 5: sync restart, then reset mid-frame
    pulse_cyc.delete();
    drive(1'b1, 32'h51, 1'b0);
    drive(1'b1, 32'h51, 1'b0);
    drive(1'b1, 32'h11, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h11, 1'b0);
    drain();
    chk("t5_pulses", longint'(pulse_cyc.size()), 1);
    chk("t5_value", longint'(data_out), 16'h0004);
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h11, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_midrst");
    frame.delete(); exp_tap = 0; sat_exp = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    drive(1'b1, 32'h11, 1'b0);
    idle(4);

    // sync on what would have been the final tap
    frame.delete();
    drive(1'b1, 32'h11, 1'b1);
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h31, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h11, 1'b0);
    drain();

    // 6: large positive sum
    frame4(32'h7FFF_FFF1, 0);
    drain();
`ifdef SATURATE_EN
    chk("t6_value", longint'(data_out), 16'h7FFF);
    chk("t6_sat", longint'(sat), 1);
`else
    chk("t6_value", longint'(data_out), 16'hFFFC);
    chk("t6_sat", longint'(sat), 0);
`endif

    // Randomized frames with gaps, syncs and full-range products
    for (int n = 0; n < 300; n++) begin
      bit          v = ($urandom_range(0, 3) != 0);
      bit          s = ($urandom_range(0, 19) == 0);
      logic [31:0] p = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h1)
                                                   : (32'($signed(16'($urandom))) | 32'h1);
      drive(v, p, s);
    end
    idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
